lsu_mem_ctrl: RTL and testbench

//   Load/store initiator between the core execute stage and data_memory.

---
 rtl/lsu_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one RV32 request at a time onto a word-wide memory port.
// Loads are extracted and extended; SB/SH are done as read-modify-write.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DW     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [DW-1:0]     i_req_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [DW-1:0]     o_rsp_rdata,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DW-1:0]     o_mem_wdata,
    input  logic [DW-1:0]     i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [2:0] F3_W = 3'b010;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rword_q, rword_d;
    logic [DW-1:0]     rsp_q, rsp_d;
    logic              err_q, err_d;

    logic          req_legal;
    logic          req_misal;
    logic [DW-1:0] load_val;
    logic [DW-1:0] merged;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    // High address bits are intentionally dropped so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

    always_comb begin
        req_legal = 1'b0;
        case (i_req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !i_req_we;
            default:                req_legal = 1'b0;
        endcase
    end

    always_comb begin
        req_misal = 1'b0;
        case (i_req_funct3[1:0])
            2'b01:   req_misal = i_req_addr[0];
            2'b10:   req_misal = (i_req_addr[1:0] != 2'b00);
            default: req_misal = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte  = i_mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        load_val = '0;
        unique case (1'b1)
            (f3_q == 3'b000): load_val = {{24{ld_byte[7]}}, ld_byte};
            (f3_q == 3'b100): load_val = {24'd0, ld_byte};
            (f3_q == 3'b001): load_val = {{16{ld_half[15]}}, ld_half};
            (f3_q == 3'b101): load_val = {16'd0, ld_half};
            (f3_q == 3'b010): load_val = i_mem_rdata;
            default:          load_val = '0;
        endcase
    end

    // Store lanes overlay the word captured during RD.
    always_comb begin
        merged = rword_q;
        if (f3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rword_d = rword_q;
        rsp_d   = rsp_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    f3_d    = i_req_funct3;
                    addr_d  = i_req_addr[ADDR_W+1:0];
                    wdata_d = i_req_wdata;
                    rword_d = '0;
                    rsp_d   = '0;
                    if (!req_legal || req_misal) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = (i_req_we && i_req_funct3 == F3_W)
                                  ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                rword_d = i_mem_rdata;
                if (we_q) begin
                    state_d = S_WR;
                end else begin
                    rsp_d   = load_val;
                    state_d = S_RSP;
                end
            end
            S_WR:    state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rword_q <= '0;
            rsp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rword_q <= rword_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_rsp_valid = (state_q == S_RSP);
    assign o_rsp_err   = (state_q == S_RSP) && err_q;
    assign o_rsp_rdata = (state_q == S_RSP) ? rsp_q : '0;
    assign o_mem_we    = (state_q == S_WR);
    assign o_mem_addr  = (state_q == S_RD || state_q == S_WR)
                         ? addr_q[ADDR_W+1:2] : '0;
    assign o_mem_wdata = (state_q != S_WR) ? '0
                       : (f3_q == F3_W) ? wdata_q : merged;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a behavioural 1024-word memory.
// Expected values are hand-computed from the preloaded memory image.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int errs;
    int checks;

    int          r_lat;
    int          r_wecnt;
    int          r_badwd;
    logic [9:0]  r_weaddr;
    logic [31:0] r_rdata;
    logic        r_err;

    lsu_mem_ctrl #(.ADDR_W(10), .DW(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_f3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_err    (rsp_err),
        .o_rsp_rdata  (rsp_rdata),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then scramble the inputs to prove they are latched.
    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_f3    = f3;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = ~we;
        req_f3    = 3'b111;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hDEAD_BEEF;
        r_lat    = -1;
        r_wecnt  = 0;
        r_badwd  = 0;
        r_weaddr = '0;
        r_rdata  = '0;
        r_err    = 1'b0;
        for (int i = 0; i < 8 && r_lat < 0; i++) begin
            @(negedge clk);
            if (mem_we) begin
                r_wecnt++;
                r_weaddr = mem_addr;
            end else if (mem_wdata != 32'd0) begin
                r_badwd++;
            end
            if (rsp_valid) begin
                r_lat   = i;
                r_rdata = rsp_rdata;
                r_err   = rsp_err;
            end
        end
        if (r_lat < 0) chk("rsp_timeout", 32'd0, 32'd1);
        chk("wdata_idle0", r_badwd, 32'd0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] exp);
        run(1'b0, f3, a, 32'h0);
        chk({tag, "_lat"}, r_lat, 32'd1);
        chk({tag, "_data"}, r_rdata, exp);
        chk({tag, "_err"}, {31'd0, r_err}, 32'd0);
        chk({tag, "_nowe"}, r_wecnt, 32'd0);
    endtask

    task automatic bad(input string tag, input logic we,
                       input logic [2:0] f3, input logic [31:0] a);
        run(we, f3, a, 32'h1234_5678);
        chk({tag, "_lat"}, r_lat, 32'd0);
        chk({tag, "_err"}, {31'd0, r_err}, 32'd1);
        chk({tag, "_data"}, r_rdata, 32'd0);
        chk({tag, "_nowe"}, r_wecnt, 32'd0);
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_f3    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1] = 32'h8765_4321;

        #12;
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        load("lw4", 3'b010, 32'h4, 32'h8765_4321);
        load("lb7", 3'b000, 32'h7, 32'hFFFF_FF87);
        load("lbu7", 3'b100, 32'h7, 32'h0000_0087);
        load("lh6", 3'b001, 32'h6, 32'hFFFF_8765);
        load("lhu4", 3'b101, 32'h4, 32'h0000_4321);
        load("lb4", 3'b000, 32'h4, 32'h0000_0021);

        run(1'b1, 3'b000, 32'h5, 32'h0000_00AA);
        chk("sb5_lat", r_lat, 32'd2);
        chk("sb5_wecnt", r_wecnt, 32'd1);
        chk("sb5_weaddr", {22'd0, r_weaddr}, 32'd1);
        chk("sb5_rdata", r_rdata, 32'd0);
        chk("sb5_mem", mem[1], 32'h8765_AA21);

        load("lb5", 3'b000, 32'h5, 32'hFFFF_FFAA);
        load("lw_wrap", 3'b010, 32'h0000_1004, 32'h8765_AA21);

        run(1'b1, 3'b010, 32'h0, 32'h0000_0001);
        chk("sw0_lat", r_lat, 32'd1);
        chk("sw0_wecnt", r_wecnt, 32'd1);
        chk("sw0_weaddr", {22'd0, r_weaddr}, 32'd0);
        chk("sw0_mem", mem[0], 32'd1);
        chk("sw0_mem1", mem[1], 32'h8765_AA21);

        run(1'b1, 3'b001, 32'h6, 32'h1234_BEEF);
        chk("sh6_lat", r_lat, 32'd2);
        chk("sh6_wecnt", r_wecnt, 32'd1);
        chk("sh6_mem", mem[1], 32'hBEEF_AA21);

        bad("lw2", 1'b0, 3'b010, 32'h2);
        bad("sh3", 1'b1, 3'b001, 32'h3);
        bad("f3_011", 1'b0, 3'b011, 32'h4);
        bad("sbu", 1'b1, 3'b100, 32'h4);
        chk("bad_mem0", mem[0], 32'd1);
        chk("bad_mem1", mem[1], 32'hBEEF_AA21);

        // Reset lands in the WR cycle of an SB; the write must not commit.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_f3    = 3'b000;
        req_addr  = 32'h4;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst6_rd_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rst6_wr_we", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst6_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rst6_wd_drop", mem_wdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst6_mem1", mem[1], 32'hBEEF_AA21);
        chk("rst6_ready", {31'd0, req_ready}, 32'd1);
        chk("rst6_rspv", {31'd0, rsp_valid}, 32'd0);

        load("post_rst", 3'b101, 32'h6, 32'h0000_BEEF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
